// File: rtl/fir_pkg.sv
// Shared constants, FSM state encodings and a width helper for the FIR MAC sequencer.
package fir_pkg;

   localparam int FIR_DATA_W = 16;
   localparam int FIR_ACC_W  = 39;

   localparam logic [1:0] ST_CLEAR = 2'd0;
   localparam logic [1:0] ST_IDLE  = 2'd1;
   localparam logic [1:0] ST_MAC   = 2'd2;
   localparam logic [1:0] ST_OUT   = 2'd3;

   // Number of address bits needed to index 'value' entries (at least 1).
   function automatic int clog2(input int value);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/alu.sv
// Combinational multiply-accumulate responder: totalSumOut = inputX*inputB + totalSumIn.
module alu #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 39
) (
   input  logic [DATA_W-1:0] inputX,
   input  logic [DATA_W-1:0] inputB,
   input  logic [ACC_W-1:0]  totalSumIn,
   output logic [ACC_W-1:0]  totalSumOut
);

   assign totalSumOut = ACC_W'(inputX) * ACC_W'(inputB) + totalSumIn;

endmodule

// File: rtl/fir_delay_line.sv
// Circular sample buffer; the newest sample sits at wr_ptr and reads are taken k entries back.
module fir_delay_line
   import fir_pkg::*;
#(
   parameter int TAPS   = 128,
   parameter int DATA_W = FIR_DATA_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     clr_en,
   input  logic [clog2(TAPS)-1:0]   clr_addr,
   input  logic [clog2(TAPS)-1:0]   rd_offset,
   output logic [DATA_W-1:0]        rd_data
);

   localparam int AW = clog2(TAPS);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [DATA_W-1:0] mem_q [TAPS];
   logic [DATA_W-1:0] mem_d [TAPS];

   // Next buffer contents: clearing wins, otherwise a write lands one slot past the current head.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      if (clr_en) begin
         mem_d[clr_addr] = '0;
      end else if (wr_en) begin
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
         mem_d[wr_ptr_d] = wr_data;
      end
   end

   // Register the head pointer and buffer; reset only rewinds the pointer, contents are zeroed by CLEAR.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         mem_q    <= mem_d;
      end
   end

   assign rd_data = mem_q[wr_ptr_q - rd_offset];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequences one FIR output per accepted sample by walking all taps through an external MAC ALU.
module fir_mac_sequencer
   import fir_pkg::*;
#(
   parameter int TAPS   = 128,
   parameter int DATA_W = FIR_DATA_W,
   parameter int ACC_W  = FIR_ACC_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_sample,
   input  logic                     coef_we,
   input  logic [clog2(TAPS)-1:0]   coef_addr,
   input  logic [DATA_W-1:0]        coef_data,
   output logic [DATA_W-1:0]        alu_inputX,
   output logic [DATA_W-1:0]        alu_inputB,
   output logic [ACC_W-1:0]         alu_totalSumIn,
   input  logic [ACC_W-1:0]         alu_totalSumOut,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ACC_W-1:0]         out_data,
   output logic                     busy
);

   localparam int AW = clog2(TAPS);
   localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);
   localparam logic [AW-1:0] CNT_ONE  = AW'(1);

   logic [1:0]        state_q, state_d;
   logic [AW-1:0]     cnt_q, cnt_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [DATA_W-1:0] coef_q [TAPS];
   logic [DATA_W-1:0] coef_d [TAPS];
   logic              dl_we, dl_clr;
   logic [DATA_W-1:0] dl_rd_data;

   fir_delay_line #(
      .TAPS   (TAPS),
      .DATA_W (DATA_W)
   ) u_delay_line (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (dl_we),
      .wr_data   (in_sample),
      .clr_en    (dl_clr),
      .clr_addr  (cnt_q),
      .rd_offset (cnt_q),
      .rd_data   (dl_rd_data)
   );

   // FSM next-state, tap counter, accumulator and coefficient-file updates.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      coef_d  = coef_q;
      dl_we   = 1'b0;
      dl_clr  = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            dl_clr        = ~reset;
            coef_d[cnt_q] = '0;
            cnt_d         = cnt_q + CNT_ONE;
            if (cnt_q == LAST_TAP) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (coef_we) begin
               coef_d[coef_addr] = coef_data;
            end
            if (in_valid) begin
               dl_we   = ~reset;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            acc_d = alu_totalSumOut;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == LAST_TAP) begin
               state_d = ST_OUT;
            end
         end
         ST_OUT: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_CLEAR;
         end
      endcase
   end

   // State registers; reset always restarts with a full clear pass and drops any in-flight result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         coef_q  <= coef_d;
      end
   end

   // Outputs decode the state, forced to their reset values while reset is held.
   always_comb begin
      in_ready       = ~reset && (state_q == ST_IDLE);
      out_valid      = ~reset && (state_q == ST_OUT);
      busy           = reset || (state_q != ST_IDLE);
      out_data       = out_valid ? acc_q : '0;
      alu_totalSumIn = reset ? '0 : acc_q;
      alu_inputX     = '0;
      alu_inputB     = '0;
      if (~reset && (state_q == ST_MAC)) begin
         alu_inputX = dl_rd_data;
         alu_inputB = coef_q[cnt_q];
      end
   end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench: a 4-tap and a 128-tap sequencer, each driving a real alu, checked against a sum-of-products model.
module tb_fir_mac_sequencer;

   logic clk;
   int   checks   = 0;
   int   failures = 0;

   logic        rst4, iv4, ir4, cwe4, ov4, or4, busy4;
   logic [15:0] is4, cd4, ax4, ab4;
   logic [1:0]  ca4;
   logic [33:0] asi4, aso4, od4;

   logic        rstB, ivB, irB, cweB, ovB, orB, busyB;
   logic [15:0] isB, cdB, axB, abB;
   logic [6:0]  caB;
   logic [38:0] asiB, asoB, odB;

   logic [15:0] c4 [4];
   logic [63:0] hist4 [$];
   logic [63:0] last_y4;

   fir_mac_sequencer #(.TAPS(4), .DATA_W(16), .ACC_W(34)) u_dut4 (
      .clk(clk), .reset(rst4), .in_valid(iv4), .in_ready(ir4), .in_sample(is4),
      .coef_we(cwe4), .coef_addr(ca4), .coef_data(cd4),
      .alu_inputX(ax4), .alu_inputB(ab4), .alu_totalSumIn(asi4), .alu_totalSumOut(aso4),
      .out_valid(ov4), .out_ready(or4), .out_data(od4), .busy(busy4)
   );

   alu #(.DATA_W(16), .ACC_W(34)) u_alu4 (
      .inputX(ax4), .inputB(ab4), .totalSumIn(asi4), .totalSumOut(aso4)
   );

   fir_mac_sequencer #(.TAPS(128), .DATA_W(16), .ACC_W(39)) u_dut128 (
      .clk(clk), .reset(rstB), .in_valid(ivB), .in_ready(irB), .in_sample(isB),
      .coef_we(cweB), .coef_addr(caB), .coef_data(cdB),
      .alu_inputX(axB), .alu_inputB(abB), .alu_totalSumIn(asiB), .alu_totalSumOut(asoB),
      .out_valid(ovB), .out_ready(orB), .out_data(odB), .busy(busyB)
   );

   alu #(.DATA_W(16), .ACC_W(39)) u_alu128 (
      .inputX(axB), .inputB(abB), .totalSumIn(asiB), .totalSumOut(asoB)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // y[n] = sum over k of c[k] * x[n-k]; history index 0 is the newest sample, missing history is zero.
   function automatic logic [63:0] model4();
      logic [63:0] s;
      s = '0;
      for (int k = 0; k < 4; k++) begin
         if (k < hist4.size()) begin
            s += 64'(c4[k]) * hist4[k];
         end
      end
      return s;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to one time unit after the next falling edge.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Hold reset for ncyc edges, then confirm the clear pass lasts exactly 4 cycles.
   task automatic resetClear4(input int ncyc);
      int n;
      rst4 = 1'b1;
      iv4  = 1'b0;
      cwe4 = 1'b0;
      #1;
      repeat (ncyc) begin
         checkOutput("rst_in_ready", 64'(ir4), 64'd0);
         checkOutput("rst_out_valid", 64'(ov4), 64'd0);
         checkOutput("rst_busy", 64'(busy4), 64'd1);
         checkOutput("rst_out_data", 64'(od4), 64'd0);
         step();
      end
      rst4 = 1'b0;
      #1;
      n = 0;
      while (ir4 !== 1'b1 && n < 20) begin
         checkOutput("clr_out_valid", 64'(ov4), 64'd0);
         checkOutput("clr_busy", 64'(busy4), 64'd1);
         n++;
         step();
      end
      checkOutput("clear_cycles", 64'(n), 64'd4);
      checkOutput("idle_busy", 64'(busy4), 64'd0);
      for (int k = 0; k < 4; k++) c4[k] = '0;
      hist4.delete();
   endtask

   task automatic writeCoef4(input logic [1:0] addr, input logic [15:0] data);
      cwe4 = 1'b1;
      ca4  = addr;
      cd4  = data;
      step();
      cwe4 = 1'b0;
      c4[addr] = data;
   endtask

   // Offer one sample in an IDLE cycle (optionally with a same-cycle coef write or a write during MAC)
   // and check latency and result.
   task automatic applyStimulus(input logic [15:0] s, input logic cw, input logic [1:0] ca,
                                input logic [15:0] cd, input logic mac_cw);
      logic [63:0] exp;
      int lat;
      iv4  = 1'b1;
      is4  = s;
      cwe4 = cw;
      ca4  = ca;
      cd4  = cd;
      #1;
      checkOutput("accept_ready", 64'(ir4), 64'd1);
      if (cw) c4[ca] = cd;
      hist4.push_front(64'(s));
      exp = model4();
      step();
      iv4  = 1'b0;
      cwe4 = 1'b0;
      lat  = 1;
      while (ov4 !== 1'b1 && lat < 40) begin
         if (mac_cw && lat == 2) begin
            cwe4 = 1'b1;
            ca4  = 2'd0;
            cd4  = 16'd9;
         end else begin
            cwe4 = 1'b0;
         end
         step();
         lat++;
      end
      cwe4 = 1'b0;
      checkOutput("latency", 64'(lat), 64'd5);
      checkOutput("y", 64'(od4), exp);
      last_y4 = exp;
   endtask

   // With out_ready high the handshake completes and the next cycle is IDLE again.
   task automatic finishOut4();
      step();
      checkOutput("post_out_valid", 64'(ov4), 64'd0);
      checkOutput("post_in_ready", 64'(ir4), 64'd1);
   endtask

   initial begin
      int n;
      int lat;
      int bp;
      logic [15:0] rs, rd;
      logic [1:0]  ra;
      logic        rw;
      logic [63:0] lastB;

      rst4 = 1'b1; iv4 = 1'b0; is4 = '0; cwe4 = 1'b0; ca4 = '0; cd4 = '0; or4 = 1'b1;
      rstB = 1'b1; ivB = 1'b0; isB = '0; cweB = 1'b0; caB = '0; cdB = '0; orB = 1'b1;
      last_y4 = '0;
      step();

      // Reset and clear, coefficient load, then the impulse response.
      resetClear4(2);
      writeCoef4(2'd0, 16'd1);
      writeCoef4(2'd1, 16'd2);
      writeCoef4(2'd2, 16'd3);
      writeCoef4(2'd3, 16'd4);
      applyStimulus(16'd1, 1'b0, 2'd0, 16'd0, 1'b0); finishOut4();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(16'd0, 1'b0, 2'd0, 16'd0, 1'b0);
         finishOut4();
      end

      // Coefficient write during MAC is ignored for this and the following result.
      applyStimulus(16'd3, 1'b0, 2'd0, 16'd0, 1'b1); finishOut4();
      applyStimulus(16'd2, 1'b0, 2'd0, 16'd0, 1'b0); finishOut4();

      // Coefficient write in the accept cycle applies to that sample.
      applyStimulus(16'd1, 1'b1, 2'd0, 16'd9, 1'b0); finishOut4();

      // Backpressure: result held for 10 cycles while the next sample waits.
      or4 = 1'b0;
      applyStimulus(16'd5, 1'b0, 2'd0, 16'd0, 1'b0);
      iv4 = 1'b1;
      is4 = 16'd7;
      for (int i = 0; i < 10; i++) begin
         checkOutput("bp_valid", 64'(ov4), 64'd1);
         checkOutput("bp_data", 64'(od4), last_y4);
         checkOutput("bp_in_ready", 64'(ir4), 64'd0);
         step();
      end
      or4 = 1'b1;
      #1;
      checkOutput("hs_in_ready", 64'(ir4), 64'd0);
      step();
      checkOutput("after_hs_valid", 64'(ov4), 64'd0);
      applyStimulus(16'd7, 1'b0, 2'd0, 16'd0, 1'b0); finishOut4();

      // Randomized samples, same-cycle coefficient writes and short stalls.
      for (int i = 0; i < 16; i++) begin
         rs = 16'($urandom);
         rd = 16'($urandom);
         ra = 2'($urandom_range(0, 3));
         rw = 1'($urandom_range(0, 1));
         bp = $urandom_range(0, 2);
         if (bp > 0) or4 = 1'b0;
         applyStimulus(rs, rw, ra, rd, 1'b0);
         if (bp > 0) begin
            repeat (bp) begin
               step();
               checkOutput("rand_hold", 64'(od4), last_y4);
            end
            or4 = 1'b1;
         end
         finishOut4();
      end

      // Reset at MAC tap 2: no result, history cleared, impulse response reproduced.
      iv4 = 1'b1;
      is4 = 16'd6;
      #1;
      checkOutput("mid_accept_ready", 64'(ir4), 64'd1);
      step();
      iv4 = 1'b0;
      step();
      step();
      checkOutput("mid_out_valid", 64'(ov4), 64'd0);
      resetClear4(1);
      writeCoef4(2'd0, 16'd1);
      writeCoef4(2'd1, 16'd2);
      writeCoef4(2'd2, 16'd3);
      writeCoef4(2'd3, 16'd4);
      applyStimulus(16'd1, 1'b0, 2'd0, 16'd0, 1'b0); finishOut4();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(16'd0, 1'b0, 2'd0, 16'd0, 1'b0);
         finishOut4();
      end

      // 128-tap worst case: all-ones coefficients and samples must not wrap.
      rstB = 1'b0;
      #1;
      n = 0;
      while (irB !== 1'b1 && n < 300) begin
         n++;
         step();
      end
      checkOutput("clear128_cycles", 64'(n), 64'd128);
      for (int k = 0; k < 128; k++) begin
         cweB = 1'b1;
         caB  = 7'(k);
         cdB  = 16'hFFFF;
         step();
      end
      cweB  = 1'b0;
      lastB = '0;
      for (int s = 0; s < 128; s++) begin
         ivB = 1'b1;
         isB = 16'hFFFF;
         #1;
         checkOutput("acc128_ready", 64'(irB), 64'd1);
         step();
         ivB = 1'b0;
         lat = 1;
         while (ovB !== 1'b1 && lat < 300) begin
            step();
            lat++;
         end
         checkOutput("lat128", 64'(lat), 64'd129);
         checkOutput("y128", 64'(odB), 64'(s + 1) * 64'd65535 * 64'd65535);
         lastB = 64'(odB);
         step();
      end
      checkOutput("y128_final", lastB, 64'h7F_FF00_0080);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
